// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with async read.
// Define MEM_ARB_RR_EN for round-robin ties and MAX_HOLD preemption; default is fixed m0 priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic [1:0]        owner
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
`ifdef MEM_ARB_RR_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
`endif

  // Encoding doubles as the owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              last_served, last_nxt;  // 1 = m1 served most recently
  state_t            tie_winner;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last_served <= 1'b1;
    end else if (clk_en) begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      last_served <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_served;
`ifdef MEM_ARB_RR_EN
    tie_winner = last_served ? OWN0 : OWN1;
`else
    tie_winner = OWN0;
`endif

    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = tie_winner;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req) state_nxt = m1_req ? OWN1 : IDLE;
`ifdef MEM_ARB_RR_EN
        else if (m1_req && hold_cnt == HOLD_LAST) state_nxt = OWN1;
`endif
      end
      OWN1: begin
        if (!m1_req) state_nxt = m0_req ? OWN0 : IDLE;
`ifdef MEM_ARB_RR_EN
        else if (m0_req && hold_cnt == HOLD_LAST) state_nxt = OWN0;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    // Tenure counter restarts on every transition and saturates while owned.
    if (state_nxt != state) begin
      hold_nxt = '0;
      if (state_nxt == OWN0) last_nxt = 1'b0;
      if (state_nxt == OWN1) last_nxt = 1'b1;
    end else if (state != IDLE && hold_cnt != HOLD_MAX) begin
      hold_nxt = hold_cnt + HOLD_W'(1);
    end
  end

  always_comb begin
    owner      = state;
    m0_gnt     = (state == OWN0);
    m1_gnt     = (state == OWN1);
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    case (state)
      OWN0: begin
        mem_wr_en  = m0_we & m0_req & ~rst;
        mem_addr   = m0_addr;
        mem_w_data = m0_wdata;
        m0_rdata   = mem_r_data;
      end
      OWN1: begin
        mem_wr_en  = m1_we & m1_req & ~rst;
        mem_addr   = m1_addr;
        mem_w_data = m1_wdata;
        m1_rdata   = mem_r_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small behavioural RAM on the memory port.
// Expectations branch on MEM_ARB_RR_EN where the two builds differ.
module tb_mem_arbiter;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, mem_wr_en;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_w_data, mem_r_data;
  logic [1:0]  owner;
  logic        ram_init = 1'b1;
  logic [31:0] ram [64];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [1:0]  own;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk_100M = ~clk_100M;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk_100M(clk_100M), .rst(rst), .clk_en(clk_en),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .owner(owner)
  );

  // RAM: async read, write on enabled edges; word i preloads to A000_0000+i.
  assign mem_r_data = ram[mem_addr[7:2]];
  always @(posedge clk_100M) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 + 32'(i);
    end else if (clk_en && mem_wr_en) begin
      ram[mem_addr[7:2]] <= mem_w_data;
    end
  end

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk_100M) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] r0, r1;
      e  = exp_q.pop_front();
      r0 = (e.own == 2'b01) ? e.rd : 32'h0;
      r1 = (e.own == 2'b10) ? e.rd : 32'h0;
      tests++;
      if (owner !== e.own || m0_gnt !== (e.own == 2'b01) || m1_gnt !== (e.own == 2'b10) ||
          mem_wr_en !== e.wr || mem_addr !== e.addr || mem_w_data !== e.wd ||
          m0_rdata !== r0 || m1_rdata !== r1) begin
        fails++;
        $display("FAIL %s: got own=%b g0=%b g1=%b wr=%b addr=%h wd=%h rd0=%h rd1=%h; want own=%b wr=%b addr=%h wd=%h rd0=%h rd1=%h",
                 e.name, owner, m0_gnt, m1_gnt, mem_wr_en, mem_addr, mem_w_data, m0_rdata, m1_rdata,
                 e.own, e.wr, e.addr, e.wd, r0, r1);
      end
    end
  end

  // Queue the outputs expected in the current cycle, then advance one edge.
  task automatic tick(input string nm, input logic [1:0] own, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.name = nm; e.own = own; e.wr = wr; e.addr = addr; e.wd = wd; e.rd = rd;
    exp_q.push_back(e);
    @(posedge clk_100M); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_100M);
    #1;
    ram_init = 1'b0;

    // Reset dominates a pending write request.
    m0_req = 1; m0_we = 1; m0_addr = 32'h40;
    tick("reset_idle", 2'b00, 0, 0, 0, 0);
    rst = 0; m0_we = 0; m0_wdata = 32'h11;
    tick("first_req_idle", 2'b00, 0, 0, 0, 0);
    tick("m0_granted", 2'b01, 0, 32'h40, 32'h11, 32'hA000_0010);
    m0_we = 1; m0_addr = 32'h44; m0_wdata = 32'h1234_5678;
    tick("m0_write", 2'b01, 1, 32'h44, 32'h1234_5678, 32'hA000_0011);
    m0_we = 0;
    tick("m0_readback", 2'b01, 0, 32'h44, 32'h1234_5678, 32'h1234_5678);

    // Direct handover to m1 without an idle bubble.
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'hDEAD_BEEF;
    tick("m1_waits", 2'b01, 0, 32'h44, 32'h1234_5678, 32'h1234_5678);
    m0_req = 0;
    tick("m0_release", 2'b01, 0, 32'h44, 32'h1234_5678, 32'h1234_5678);
    tick("m1_write", 2'b10, 1, 32'h80, 32'hDEAD_BEEF, 32'hA000_0020);
    m1_we = 0;
    tick("m1_readback", 2'b10, 0, 32'h80, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Clock enable low freezes ownership while requests toggle.
    clk_en = 0;
    for (int i = 0; i < 5; i++) begin
      m0_req = ~i[0]; m1_req = i[0];
      tick("clk_en_hold", 2'b10, 0, 32'h80, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    end
    clk_en = 1; m0_req = 1; m1_req = 0;
    tick("clk_en_resume", 2'b10, 0, 32'h80, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Reset mid-access into OWN1 with clk_en low must not write.
    m0_req = 0; m1_req = 1;
    tick("back_to_m0", 2'b01, 0, 32'h44, 32'h1234_5678, 32'h1234_5678);
    m1_we = 1; m1_addr = 32'h84; m1_wdata = 32'hCAFE_F00D; clk_en = 0; rst = 1;
    tick("rst_mid_write", 2'b10, 0, 32'h84, 32'hCAFE_F00D, 32'hA000_0021);
    rst = 0;
    tick("after_rst_idle", 2'b00, 0, 0, 0, 0);
    tick("after_rst_gated", 2'b00, 0, 0, 0, 0);
    m1_we = 0; clk_en = 1;
    tick("idle_enabled", 2'b00, 0, 0, 0, 0);
    tick("ram_unchanged", 2'b10, 0, 32'h84, 32'hCAFE_F00D, 32'hA000_0021);
    m1_req = 0;
    tick("m1_release", 2'b10, 0, 32'h84, 32'hCAFE_F00D, 32'hA000_0021);

    // Ties: m0 wins first after reset; round-robin flips the second.
    rst = 1; m0_addr = 32'h40; m0_wdata = 0; m1_addr = 32'h80; m1_wdata = 0;
    tick("reset2", 2'b00, 0, 0, 0, 0);
    rst = 0; m0_req = 1; m1_req = 1;
    tick("tie1_idle", 2'b00, 0, 0, 0, 0);
    m0_req = 0; m1_req = 0;
    tick("tie1_m0", 2'b01, 0, 32'h40, 0, 32'hA000_0010);
    m0_req = 1; m1_req = 1;
    tick("tie2_idle", 2'b00, 0, 0, 0, 0);
    m0_req = 0; m1_req = 0;
`ifdef MEM_ARB_RR_EN
    tick("tie2_m1", 2'b10, 0, 32'h80, 0, 32'hDEAD_BEEF);
`else
    tick("tie2_m0", 2'b01, 0, 32'h40, 0, 32'hA000_0010);
`endif
    tick("tie2_idle_after", 2'b00, 0, 0, 0, 0);

    // Continuous contention from a fresh reset.
    rst = 1;
    tick("reset3", 2'b00, 0, 0, 0, 0);
    rst = 0; m0_req = 1; m1_req = 1;
    tick("contend_idle", 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
`ifdef MEM_ARB_RR_EN
      if (((i / 8) % 2) == 0) tick("contend_run_m0", 2'b01, 0, 32'h40, 0, 32'hA000_0010);
      else                    tick("contend_run_m1", 2'b10, 0, 32'h80, 0, 32'hDEAD_BEEF);
`else
      tick("contend_m0_holds", 2'b01, 0, 32'h40, 0, 32'hA000_0010);
`endif
    end
    m0_req = 0; m1_req = 0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_100M);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
